// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the memory-port responder.
// States, access kinds and the latency-counter width function.
package mem_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    I_BUSY,
    D_BUSY,
    DONE,
    REST
  } state_e;

  typedef enum logic [1:0] {
    ACC_I,
    ACC_DR,
    ACC_DW
  } acc_kind_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  function automatic int cnt_width(input int latency);
    int w;
    w = clog2(latency + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_resp_arbiter.sv
// Request pick for the responder: data over fetch, then a
// latched record of the accepted access (kind, index, wdata).
module mem_resp_arbiter
  import mem_resp_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 16,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_readM,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              d_readM,
  input  logic              d_writeM,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [WORD_W-1:0] d_wdata,
  input  logic              d_block,
  input  logic              take,
  output logic              pick_valid,
  output acc_kind_e         pick_kind,
  output logic [AW-1:0]     pick_idx,
  output logic [WORD_W-1:0] pick_wdata,
  output logic [AW-1:0]     d_idx,
  output acc_kind_e         rec_kind,
  output logic [AW-1:0]     rec_idx,
  output logic [WORD_W-1:0] rec_wdata
);

  logic d_any;
  logic d_go;
  logic i_go;
  logic unused_hi;

  assign d_any = d_readM | d_writeM;
  assign d_go  = d_any & ~d_block;
  // A blocked data request still holds off fetches.
  assign i_go  = i_readM & ~d_any;

  assign d_idx      = d_address[AW-1:0];
  assign pick_wdata = d_wdata;
  assign unused_hi  = ^{i_address[ADDR_W-1:AW],
                        d_address[ADDR_W-1:AW]};

  always_comb begin
    pick_valid = 1'b0;
    pick_kind  = ACC_I;
    pick_idx   = i_address[AW-1:0];
    unique case (1'b1)
      d_go: begin
        pick_valid = 1'b1;
        pick_kind  = d_writeM ? ACC_DW : ACC_DR;
        pick_idx   = d_address[AW-1:0];
      end
      i_go: begin
        pick_valid = 1'b1;
        pick_kind  = ACC_I;
        pick_idx   = i_address[AW-1:0];
      end
      default: begin
        pick_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rec_kind  <= ACC_I;
      rec_idx   <= '0;
      rec_wdata <= '0;
    end else if (take && pick_valid) begin
      rec_kind  <= pick_kind;
      rec_idx   <= pick_idx;
      rec_wdata <= pick_wdata;
    end
  end

endmodule

// File: rtl/mem_port_responder.sv
// Fixed-latency fetch/data responder on one shared word array.
// Optional posted write buffer: define WRITE_BUFFER_EN.
module mem_port_responder
  import mem_resp_pkg::*;
#(
  parameter int WORD_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_readM,
  input  logic [ADDR_W-1:0] i_address,
  output logic [WORD_W-1:0] i_data,
  output logic              complete1,
  input  logic              d_readM,
  input  logic              d_writeM,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [WORD_W-1:0] d_wdata,
  output logic [WORD_W-1:0] d_rdata,
  output logic              complete2
);

  localparam int AW   = clog2(DEPTH);
  localparam int CW   = cnt_width(LATENCY);
  localparam int LAST = (LATENCY > 1) ? LATENCY - 2 : 0;

  state_e            state;
  logic [CW-1:0]     cnt;
  logic [WORD_W-1:0] mem [DEPTH];

  logic              take;
  logic              busy;
  logic              do_fin;
  logic              fast_w;
  logic              fast_r;
  logic              d_block;
  logic              pick_valid;
  acc_kind_e         pick_kind;
  logic [AW-1:0]     pick_idx;
  logic [WORD_W-1:0] pick_wdata;
  logic [AW-1:0]     d_idx;
  acc_kind_e         rec_kind;
  logic [AW-1:0]     rec_idx;
  logic [WORD_W-1:0] rec_wdata;
  acc_kind_e         f_kind;
  logic [AW-1:0]     f_idx;
  logic [WORD_W-1:0] f_wdata;
  logic [WORD_W-1:0] rd_word;

  assign take = (state == IDLE);
  assign busy = (state == I_BUSY) || (state == D_BUSY);

  mem_resp_arbiter #(
    .WORD_W(WORD_W),
    .ADDR_W(ADDR_W),
    .AW    (AW)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_readM   (i_readM),
    .i_address (i_address),
    .d_readM   (d_readM),
    .d_writeM  (d_writeM),
    .d_address (d_address),
    .d_wdata   (d_wdata),
    .d_block   (d_block),
    .take      (take),
    .pick_valid(pick_valid),
    .pick_kind (pick_kind),
    .pick_idx  (pick_idx),
    .pick_wdata(pick_wdata),
    .d_idx     (d_idx),
    .rec_kind  (rec_kind),
    .rec_idx   (rec_idx),
    .rec_wdata (rec_wdata)
  );

  // With LATENCY==1 the access finishes straight from IDLE.
  assign f_kind  = take ? pick_kind  : rec_kind;
  assign f_idx   = take ? pick_idx   : rec_idx;
  assign f_wdata = take ? pick_wdata : rec_wdata;

  assign do_fin =
    (take && pick_valid && !fast_w && !fast_r
     && (LATENCY == 1))
    || (busy && (cnt == CW'(LAST)));

`ifdef WRITE_BUFFER_EN
  logic              wb_valid;
  logic [AW-1:0]     wb_idx;
  logic [WORD_W-1:0] wb_data;
  logic [CW-1:0]     wb_cnt;
  logic              wb_drain;
  logic              wb_hit;

  assign wb_hit   = wb_valid && (d_idx == wb_idx);
  assign wb_drain = wb_valid && (wb_cnt == CW'(LATENCY - 1));
  assign d_block  = wb_valid
                    && (d_writeM || (d_readM && !wb_hit));
  assign fast_w   = take && pick_valid
                    && (pick_kind == ACC_DW) && !wb_valid;
  assign fast_r   = take && pick_valid
                    && (pick_kind == ACC_DR) && wb_hit;

  always_comb begin
    rd_word = mem[f_idx];
    if (wb_valid && (wb_idx == f_idx)) rd_word = wb_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid <= 1'b0;
      wb_idx   <= '0;
      wb_data  <= '0;
      wb_cnt   <= '0;
    end else if (fast_w) begin
      wb_valid <= 1'b1;
      wb_idx   <= pick_idx;
      wb_data  <= pick_wdata;
      wb_cnt   <= '0;
    end else if (wb_valid) begin
      if (wb_drain) wb_valid <= 1'b0;
      else          wb_cnt   <= wb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && do_fin && (f_kind == ACC_DW))
      mem[f_idx] <= f_wdata;
    else if (reset_n && wb_drain)
      mem[wb_idx] <= wb_data;
  end
`else
  assign d_block = 1'b0;
  assign fast_w  = 1'b0;
  assign fast_r  = 1'b0;
  assign rd_word = mem[f_idx];

  // Array is deliberately not reset; gating keeps an
  // access abandoned by reset from touching it.
  always_ff @(posedge clk) begin
    if (reset_n && do_fin && (f_kind == ACC_DW))
      mem[f_idx] <= f_wdata;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      complete1 <= 1'b0;
      complete2 <= 1'b0;
      i_data    <= '0;
      d_rdata   <= '0;
    end else begin
      complete1 <= 1'b0;
      complete2 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fast_w) begin
            state     <= DONE;
            complete2 <= 1'b1;
          end else if (fast_r) begin
            state     <= DONE;
            complete2 <= 1'b1;
            d_rdata   <= rd_word;
          end else if (pick_valid && (LATENCY > 1)) begin
            state <= (pick_kind == ACC_I) ? I_BUSY : D_BUSY;
            cnt   <= '0;
          end
        end
        I_BUSY, D_BUSY: begin
          if (!do_fin) cnt <= cnt + 1'b1;
        end
        DONE:    state <= REST;
        REST:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (do_fin) begin
        state <= DONE;
        unique case (f_kind)
          ACC_I: begin
            complete1 <= 1'b1;
            i_data    <= rd_word;
          end
          ACC_DR: begin
            complete2 <= 1'b1;
            d_rdata   <= rd_word;
          end
          default: complete2 <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed bench for mem_port_responder (LATENCY=4).
module tb_mem_port_responder;
  import mem_resp_pkg::*;

  localparam int L = 4;
`ifdef WRITE_BUFFER_EN
  localparam int WLAT = 1;
  localparam int HLAT = 1;
`else
  localparam int WLAT = L;
  localparam int HLAT = L;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] i_data;
  logic        complete1;
  logic        d_readM;
  logic        d_writeM;
  logic [15:0] d_address;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        complete2;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  mem_port_responder #(
    .WORD_W(16), .ADDR_W(16),
    .DEPTH(256), .LATENCY(L)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_readM  (i_readM),
    .i_address(i_address),
    .i_data   (i_data),
    .complete1(complete1),
    .d_readM  (d_readM),
    .d_writeM (d_writeM),
    .d_address(d_address),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .complete2(complete2)
  );

  always @(negedge clk)
    if (complete1 && complete2) overlap++;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic        ird;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        exp_c1;
    logic [15:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t tv[10];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_access(input logic rd, wr, ird,
                           input logic [15:0] addr, wdata,
                           output int lat,
                           output logic c1, c2);
    d_readM = rd; d_writeM = wr; i_readM = ird;
    d_address = addr; i_address = addr; d_wdata = wdata;
    lat = -1; c1 = 1'b0; c2 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (complete1 || complete2) begin
        lat = k; c1 = complete1; c2 = complete2;
        break;
      end
    end
    d_readM = 0; d_writeM = 0; i_readM = 0;
    repeat (2) step();
  endtask

  task automatic wr_then_rd(input string nm,
                            input logic [15:0] addr, wdata,
                            output int tw, tr,
                            output logic [15:0] rdat,
                            output logic wbv);
    int ph;
    ph = 0; tw = -1; tr = -1; rdat = '0; wbv = 1'b0;
    d_address = addr; d_wdata = wdata; d_writeM = 1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (complete2 && ph == 0) begin
        tw = k; ph = 1;
        d_writeM = 0; d_readM = 1;
      end else if (complete2 && ph == 1) begin
        tr = k; rdat = d_rdata;
`ifdef WRITE_BUFFER_EN
        wbv = dut.wb_valid;
`endif
        d_readM = 0;
        break;
      end
    end
    d_readM = 0; d_writeM = 0;
    if (tr < 0) $display("FAIL %s_timeout", nm);
    repeat (L + 2) step();
  endtask

  initial begin
    int lat, np, t1, t2, tw, tr, seen;
    logic c1, c2, wbv;
    logic [15:0] rdat, d2;
    int tim[3];
    logic [15:0] dat[3];

    tv[0] = '{"w10", 0,1,0, 16'h0010, 16'hBEEF, 0, 16'h0000, WLAT};
    tv[1] = '{"w20", 0,1,0, 16'h0020, 16'h1234, 0, 16'h0000, WLAT};
    tv[2] = '{"w40", 0,1,0, 16'h0040, 16'h0001, 0, 16'h0000, WLAT};
    tv[3] = '{"w155",0,1,0, 16'h0155, 16'h7777, 0, 16'h0000, WLAT};
    tv[4] = '{"r55", 1,0,0, 16'h0055, 16'h0000, 0, 16'h7777, L};
    tv[5] = '{"r10", 1,0,0, 16'h0010, 16'h0000, 0, 16'hBEEF, L};
    tv[6] = '{"rff20",1,0,0,16'hFF20, 16'h0000, 0, 16'h1234, L};
    tv[7] = '{"rw60",1,1,0, 16'h0060, 16'h4242, 0, 16'h1234, WLAT};
    tv[8] = '{"r60", 1,0,0, 16'h0060, 16'h0000, 0, 16'h4242, L};
    tv[9] = '{"i40", 0,0,1, 16'h0040, 16'h0000, 1, 16'h0001, L};

    reset_n = 0; i_readM = 0; d_readM = 0; d_writeM = 0;
    i_address = 0; d_address = 0; d_wdata = 0;
    repeat (3) @(negedge clk);
    check("rst_c1", complete1, 0);
    check("rst_c2", complete2, 0);
    check("rst_idata", i_data, 0);
    check("rst_drdata", d_rdata, 0);
    check("rst_state", dut.state, IDLE);
    reset_n = 1;

    for (int i = 0; i < 10; i++) begin
      do_access(tv[i].rd, tv[i].wr, tv[i].ird,
                tv[i].addr, tv[i].wdata, lat, c1, c2);
      check({tv[i].name, "_lat"}, lat, tv[i].exp_lat);
      check({tv[i].name, "_c1"}, c1, tv[i].exp_c1);
      check({tv[i].name, "_c2"}, c2, !tv[i].exp_c1);
      check({tv[i].name, "_data"},
            tv[i].exp_c1 ? i_data : d_rdata,
            tv[i].exp_data);
      repeat (L + 2) step();
    end

    // Fetch held from reset release: three spaced pulses.
    reset_n = 0;
    @(negedge clk);
    i_address = 16'h0010; i_readM = 1; reset_n = 1;
    np = 0;
    for (int k = 1; k <= 3 * L + 12; k++) begin
      step();
      if (complete1) begin
        if (np < 3) begin tim[np] = k; dat[np] = i_data; end
        np++;
        if (np == 3) i_readM = 0;
      end
    end
    i_readM = 0;
    check("hold_npulse", np, 3);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("hold_t%0d", j), tim[j], L + j * (L + 2));
      check($sformatf("hold_d%0d", j), dat[j], 16'hBEEF);
    end

    // Simultaneous fetch and data read: data first.
    i_address = 16'h0010; d_address = 16'h0020;
    i_readM = 1; d_readM = 1;
    t1 = -1; t2 = -1; d2 = '0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (complete2 && t2 < 0) begin
        t2 = k; d2 = d_rdata; d_readM = 0;
      end
      if (complete1 && t1 < 0) begin
        t1 = k; i_readM = 0;
      end
      if (t1 >= 0 && t2 >= 0) break;
    end
    i_readM = 0; d_readM = 0;
    check("pri_t2", t2, L);
    check("pri_d2", d2, 16'h1234);
    check("pri_t1", t1, 2 * L + 2);
    check("pri_idata", i_data, 16'hBEEF);
    repeat (L + 2) step();

    wr_then_rd("raw30", 16'h0030, 16'hA5A5, tw, tr, rdat, wbv);
    check("raw_tw", tw, WLAT);
    check("raw_tr", tr, WLAT + 2 + HLAT);
    check("raw_data", rdat, 16'hA5A5);

`ifndef WRITE_BUFFER_EN
    // Reset two cycles into a write abandons it.
    d_address = 16'h0040; d_wdata = 16'hDEAD; d_writeM = 1;
    seen = 0;
    repeat (2) begin
      step();
      if (complete2) seen++;
    end
    reset_n = 0;
    repeat (3) begin
      step();
      if (complete2) seen++;
    end
    check("abort_idata", i_data, 0);
    check("abort_drdata", d_rdata, 0);
    check("abort_state", dut.state, IDLE);
    d_writeM = 0; reset_n = 1;
    repeat (L + 3) begin
      step();
      if (complete2) seen++;
    end
    check("abort_nopulse", seen, 0);
    do_access(1, 0, 0, 16'h0040, 16'h0000, lat, c1, c2);
    check("abort_rlat", lat, L);
    check("abort_mem", d_rdata, 16'h0001);
`else
    wr_then_rd("wb50", 16'h0050, 16'h5555, tw, tr, rdat, wbv);
    check("wb_tw", tw, 1);
    check("wb_tr", tr, 4);
    check("wb_data", rdat, 16'h5555);
    check("wb_pending", wbv, 1);
`endif

    check("no_overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
